// File: rtl/pipeline_forward_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 5-stage RV32I pipeline (EX/MEM/WB rd tracking).
// Selects and stall are combinational with zero latency; stall holds IF/ID and bubble_ex inserts a NOP into ID/EX.
module pipeline_forward_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic [1:0]            forward_rs1,
  output logic [1:0]            forward_rs2,
  output logic                  stall,
  output logic                  bubble_ex,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } ex_slot_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } mem_slot_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } wb_slot_t;

  ex_slot_t  ex_q;
  ex_slot_t  ex_d;
  mem_slot_t mem_q;
  wb_slot_t  wb_q;

  // MEM beats WB so the youngest producer wins; loads in MEM have no data yet and x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic                  used,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input mem_slot_t             mem,
                                         input wb_slot_t              wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && mem.regwrite && !mem.memread && (mem.rd != '0) && (mem.rd == src)) begin
      sel = 2'b01;
    end else if (used && wb.regwrite && (wb.rd != '0) && (wb.rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    forward_rs1 = fwd_sel(ex_q.rs1_used, ex_q.rs1, mem_q, wb_q);
    forward_rs2 = fwd_sel(ex_q.rs2_used, ex_q.rs2, mem_q, wb_q);
  end

  // Flush outranks stall: the ID instruction is dead, so holding it would be pointless.
  always_comb begin
    stall = !flush && id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
            ((id_rs1_used && (id_rs1 == ex_q.rd)) || (id_rs2_used && (id_rs2 == ex_q.rd)));
    bubble_ex = stall | flush;
  end

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rs1_used = id_rs1_used;
      ex_d.rs2_used = id_rs2_used;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q.rd       <= ex_q.rd;
      mem_q.regwrite <= ex_q.valid & ex_q.regwrite;
      mem_q.memread  <= ex_q.valid & ex_q.memread;
      wb_q.rd        <= mem_q.rd;
      wb_q.regwrite  <= mem_q.regwrite;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_forward_hazard_unit.sv
// Directed vector bench for pipeline_forward_hazard_unit, built with a 4-bit stall counter to reach saturation quickly.
module tb_pipeline_forward_hazard_unit;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [RW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;
  logic [1:0]    forward_rs1;
  logic [1:0]    forward_rs2;
  logic          stall;
  logic          bubble_ex;
  logic [CW-1:0] stall_count;

  pipeline_forward_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .forward_rs1 (forward_rs1),
    .forward_rs2 (forward_rs2),
    .stall       (stall),
    .bubble_ex   (bubble_ex),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rs1;
    logic          u1;
    logic [RW-1:0] rs2;
    logic          u2;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          fl;
    logic [1:0]    f1;
    logic [1:0]    f2;
    logic          st;
    logic          bb;
    logic [CW-1:0] cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                              input logic u2, input int rd, input logic rw, input logic mr,
                              input logic fl, input int f1, input int f2, input logic st,
                              input logic bb, input int cnt);
    vec_t r;
    r.v = v;   r.rs1 = RW'(rs1); r.u1 = u1; r.rs2 = RW'(rs2); r.u2 = u2;
    r.rd = RW'(rd); r.rw = rw; r.mr = mr; r.fl = fl;
    r.f1 = 2'(f1); r.f2 = 2'(f2); r.st = st; r.bb = bb; r.cnt = CW'(cnt);
    return r;
  endfunction

  function automatic vec_t nop(input int f1, input int f2, input int cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, f1, f2, 0, 0, cnt);
  endfunction

  task automatic drive(input vec_t t);
    id_valid    = t.v;
    id_rs1      = t.rs1;
    id_rs2      = t.rs2;
    id_rs1_used = t.u1;
    id_rs2_used = t.u2;
    id_rd       = t.rd;
    id_regwrite = t.rw;
    id_memread  = t.mr;
    flush       = t.fl;
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled on the following negedge.
  task automatic run_vec(input vec_t t, input int idx, input logic chk_fwd);
    drive(t);
    @(negedge clk);
    if (chk_fwd) begin
      check($sformatf("v%0d forward_rs1", idx), int'(forward_rs1), int'(t.f1));
      check($sformatf("v%0d forward_rs2", idx), int'(forward_rs2), int'(t.f2));
    end
    check($sformatf("v%0d stall", idx), int'(stall), int'(t.st));
    check($sformatf("v%0d bubble_ex", idx), int'(bubble_ex), int'(t.bb));
    check($sformatf("v%0d stall_count", idx), int'(stall_count), int'(t.cnt));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    rst_n = 1'b0;
    drive(nop(0, 0, 0));

    // add x5,x1,x2 ; sub x6,x5,x3 back to back
    vecs.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // same pair with one NOP between
    vecs.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(mk(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(2, 0, 0));
    // x5 produced in both MEM and WB, consumer reads x5,x5
    vecs.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 1, 4, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 1, 5, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(1, 1, 0));
    // same with x0 as destination and source
    vecs.push_back(mk(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 1, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // lw x7,0(x1) ; add x8,x7,x7 -> one stall, held add then forwards from WB
    vecs.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(nop(2, 2, 1));
    // load-use candidate killed by flush
    vecs.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 7, 1, 7, 1, 8, 1, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(nop(0, 0, 1));

    // reset state
    @(negedge clk);
    check("reset forward_rs1", int'(forward_rs1), 0);
    check("reset forward_rs2", int'(forward_rs2), 0);
    check("reset stall", int'(stall), 0);
    check("reset bubble_ex", int'(bubble_ex), 0);
    check("reset stall_count", int'(stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i, 1'b1);

    // 15 further load-use pairs: counter climbs 1 -> 15 and must stick there
    exp_cnt = 1;
    for (int k = 0; k < 15; k++) begin
      run_vec(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, exp_cnt), 100 + 3 * k, 1'b0);
      run_vec(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 1, 1, exp_cnt), 101 + 3 * k, 1'b0);
      if (exp_cnt < 15) exp_cnt++;
      run_vec(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0, exp_cnt), 102 + 3 * k, 1'b0);
    end
    check("saturated stall_count", int'(stall_count), 15);

    // mid-stream asynchronous reset while a stall is being requested
    run_vec(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 15), 200, 1'b0);
    drive(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 1, 1, 15));
    @(negedge clk);
    check("pre-reset stall", int'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset forward_rs1", int'(forward_rs1), 0);
    check("async reset forward_rs2", int'(forward_rs2), 0);
    check("async reset stall", int'(stall), 0);
    check("async reset bubble_ex", int'(bubble_ex), 0);
    check("async reset stall_count", int'(stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // tracking was discarded, so the held consumer no longer sees the load
    run_vec(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0), 201, 1'b1);
    run_vec(nop(0, 0, 0), 202, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
